// File: rtl/npc_csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: address map, op encoding,
// mstatus field positions and the read-modify-write helper.
package npc_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam logic [1:0] MPP_M  = 2'b11;

    // Address decode result
    typedef struct packed {
        logic mapped;
        logic ro;
    } csr_dec_t;

    function automatic logic [63:0] csr_rmw(csr_op_e op, logic [63:0] old_v, logic [63:0] wd);
        case (op)
            CSR_OP_RW: return wd;
            CSR_OP_RS: return old_v | wd;
            CSR_OP_RC: return old_v & ~wd;
            default:   return old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// Any half write replaces the increment for that cycle.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_lo_i,
    input  logic [31:0] wdata_hi_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            cnt_d[31:0]  = wr_lo_i ? wdata_lo_i : cnt_q[31:0];
            cnt_d[63:32] = wr_hi_i ? wdata_hi_i : cnt_q[63:32];
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_unit_m.sv
// Machine-mode CSR unit: CSR read/RMW, trap entry, mret, mcycle/minstret
// counters and illegal-access detection.
module csr_unit_m
    import npc_csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter bit              HAS_CNT     = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            csr_en_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic            mret_valid_i,
    input  logic            instret_inc_i,
    output logic [XLEN-1:0] trap_target_o,
    output logic [XLEN-1:0] mret_target_o,
    output logic            mstatus_mie_o
);

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mscratch_q, mscratch_d;
    logic [63:0]     mcycle, minstret;

    csr_op_e         op;
    csr_dec_t        dec;
    logic [XLEN-1:0] rdata, mstatus_rd, wval;
    logic [63:0]     wval64;
    logic            wr_eff, csr_we;
    logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
    logic [31:0]     cnt_wd_hi;
    logic [XLEN-1:0] tvec_base, tvec_off;

    assign op         = csr_op_e'(csr_op_i);
    assign mstatus_rd = XLEN'({MPP_M, 3'b000, mpie_q, 3'b000, mie_q, 3'b000});

    always_comb begin
        dec   = '{mapped: 1'b1, ro: 1'b0};
        rdata = '0;
        case (csr_addr_i)
            CSR_MSTATUS:  rdata = mstatus_rd;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MCYCLE, CSR_CYCLE: begin
                dec.mapped = HAS_CNT;
                dec.ro     = (csr_addr_i == CSR_CYCLE);
                rdata      = HAS_CNT ? mcycle[XLEN-1:0] : '0;
            end
            CSR_MINSTRET, CSR_INSTRET: begin
                dec.mapped = HAS_CNT;
                dec.ro     = (csr_addr_i == CSR_INSTRET);
                rdata      = HAS_CNT ? minstret[XLEN-1:0] : '0;
            end
            // Upper halves only exist when a counter does not fit in one register
            CSR_MCYCLEH, CSR_CYCLEH: begin
                dec.mapped = HAS_CNT && (XLEN == 32);
                dec.ro     = (csr_addr_i == CSR_CYCLEH);
                rdata      = dec.mapped ? XLEN'(mcycle[63:32]) : '0;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                dec.mapped = HAS_CNT && (XLEN == 32);
                dec.ro     = (csr_addr_i == CSR_INSTRETH);
                rdata      = dec.mapped ? XLEN'(minstret[63:32]) : '0;
            end
            CSR_MVENDORID, CSR_MHARTID: dec.ro = 1'b1;
            default: dec.mapped = 1'b0;
        endcase
    end

    assign csr_rdata_o = rdata;

    // RS/RC with a zero mask is a pure read, legal even on read-only CSRs
    assign wr_eff        = (op == CSR_OP_RW) || ((op != CSR_OP_NONE) && (csr_wdata_i != '0));
    assign csr_illegal_o = csr_en_i && (op != CSR_OP_NONE) && (!dec.mapped || (dec.ro && wr_eff));
    assign csr_we        = csr_en_i && wr_eff && !csr_illegal_o && !trap_valid_i && !mret_valid_i;

    assign wval64 = csr_rmw(op, 64'(rdata), 64'(csr_wdata_i));
    assign wval   = wval64[XLEN-1:0];

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        if (trap_valid_i) begin
            mepc_d   = trap_pc_i & ~XLEN'(3);
            mcause_d = trap_cause_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_d  = wval[MSTATUS_MIE];
                    mpie_d = wval[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = wval & ~XLEN'(2);
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = wval & ~XLEN'(3);
                CSR_MCAUSE:   mcause_d   = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
        end
    end

    // A full-width write on XLEN=64 hits both halves at once
    assign cyc_wr_lo = csr_we && (csr_addr_i == CSR_MCYCLE);
    assign cyc_wr_hi = csr_we && ((csr_addr_i == CSR_MCYCLEH) || ((XLEN == 64) && (csr_addr_i == CSR_MCYCLE)));
    assign ins_wr_lo = csr_we && (csr_addr_i == CSR_MINSTRET);
    assign ins_wr_hi = csr_we && ((csr_addr_i == CSR_MINSTRETH) || ((XLEN == 64) && (csr_addr_i == CSR_MINSTRET)));
    assign cnt_wd_hi = (XLEN == 64) ? wval64[63:32] : wval64[31:0];

    csr_counter64 u_mcycle (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .inc_i      (1'b1),
        .wr_lo_i    (cyc_wr_lo),
        .wr_hi_i    (cyc_wr_hi),
        .wdata_lo_i (wval64[31:0]),
        .wdata_hi_i (cnt_wd_hi),
        .cnt_o      (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .inc_i      (instret_inc_i),
        .wr_lo_i    (ins_wr_lo),
        .wr_hi_i    (ins_wr_hi),
        .wdata_lo_i (wval64[31:0]),
        .wdata_hi_i (cnt_wd_hi),
        .cnt_o      (minstret)
    );

    // Vectored mode offsets only interrupts; exceptions land on the base
    assign tvec_base     = {mtvec_q[XLEN-1:2], 2'b00};
    assign tvec_off      = XLEN'({trap_cause_i[XLEN-2:0], 2'b00});
    assign trap_target_o = (mtvec_q[0] && trap_cause_i[XLEN-1]) ? tvec_base + tvec_off : tvec_base;
    assign mret_target_o = mepc_q;
    assign mstatus_mie_o = mie_q;

endmodule
